// File: rtl/branch_outcome_queue_if.sv
// Commit-slot inputs and predictor-update handshake for the branch outcome queue.
// master = commit side and predictor port; slave = the queue itself.
interface branch_outcome_queue_if #(
    parameter int AMSB  = 63,
    parameter int NPORT = 4,
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                        en;
    logic [NPORT-1:0]            xisBranch;
    logic [NPORT-1:0][AMSB:0]    xip;
    logic [NPORT-1:0]            takb;
    logic                        full;
    logic [CW-1:0]               count;
    logic                        upd_valid;
    logic [AMSB:0]               upd_ip;
    logic                        upd_takb;
    logic                        upd_ready;
    logic                        ovf;

    modport master (
        output en, xisBranch, xip, takb, upd_ready,
        input  full, count, upd_valid, upd_ip, upd_takb, ovf
    );

    modport slave (
        input  en, xisBranch, xip, takb, upd_ready,
        output full, count, upd_valid, upd_ip, upd_takb, ovf
    );
endinterface

// File: rtl/branch_outcome_queue.sv
// Compacting multi-write FIFO: up to NPORT branch outcomes in, one show-ahead record out (enqueue->visible 1 cycle).
// Backpressure: full warns commit to stall; excess records are dropped and flagged in sticky ovf.
module branch_outcome_queue #(
    parameter int AMSB  = 63,
    parameter int NPORT = 4,
    parameter int DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_outcome_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AMSB:0] ip;
        logic          takb;
    } rec_t;

    rec_t          mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          ovf;

    logic          deq;
    logic [CW-1:0] space;
    logic [CW-1:0] written;
    logic          drop;
    logic [NPORT-1:0] wr_en;
    logic [PW-1:0] wr_addr [NPORT];
    logic [CW-1:0] count_next;

    // Valid slots take consecutive addresses in slot order, so skipped slots leave no holes.
    always_comb begin
        deq     = (count != '0) && bus.upd_ready;
        space   = CW'(DEPTH) - count + {{(CW-1){1'b0}}, deq};
        written = '0;
        drop    = 1'b0;
        wr_en   = '0;
        for (int n = 0; n < NPORT; n++) begin
            wr_addr[n] = tail + written[PW-1:0];
            if (bus.en && bus.xisBranch[n]) begin
                if (written < space) begin
                    wr_en[n] = 1'b1;
                    written  = written + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
        count_next = count + written - {{(CW-1){1'b0}}, deq};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            head  <= head + {{(PW-1){1'b0}}, deq};
            tail  <= tail + written[PW-1:0];
            count <= count_next;
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NPORT; n++) begin
            if (wr_en[n]) begin
                mem[wr_addr[n]] <= '{ip: bus.xip[n], takb: bus.takb[n]};
            end
        end
    end

    assign bus.count     = count;
    assign bus.upd_valid = (count != '0);
    assign bus.upd_ip    = mem[head].ip;
    assign bus.upd_takb  = mem[head].takb;
    assign bus.full      = (CW'(DEPTH) - count) < CW'(NPORT);
    assign bus.ovf       = ovf;
endmodule
